// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: one request at a time, fixed access latency,
// word RAM below 0xFE00 plus memory-mapped keyboard and display registers.
module lc3_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 3,
  parameter     INIT_FILE   = "lc3mem.hex"
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  output logic        r,
  output logic [15:0] mem_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [15:0]           cap_addr;
  logic [15:0]           cap_data;
  logic                  cap_rw;
  logic                  kb_ready;
  logic [7:0]            kbdr;
  logic [15:0]           ram [DEPTH];

  logic                  fire;
  logic [15:0]           acc_addr;
  logic [15:0]           acc_data;
  logic                  acc_rw;
  logic                  is_ram;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [15:0]           rd_val;

  // The access happens on the edge that enters RESP; with zero latency that
  // is the capture edge itself, so the live request inputs are used then.
  always_comb begin
    fire     = 1'b0;
    acc_addr = cap_addr;
    acc_data = cap_data;
    acc_rw   = cap_rw;
    if (state == ST_IDLE) begin
      acc_addr = mar;
      acc_data = mdr;
      acc_rw   = r_w;
      fire     = mio_en && NO_WAIT;
    end else if (state == ST_WAIT) begin
      fire = (cnt == 4'd1);
    end
  end

  assign is_ram  = (acc_addr < IO_BASE);
  assign ram_idx = acc_addr[DEPTH_LOG2-1:0];

  // Read data selection across RAM and the device registers.
  always_comb begin
    rd_val = 16'h0000;
    if (is_ram) begin
      rd_val = ram[ram_idx];
    end else begin
      case (acc_addr)
        KBSR_ADDR: rd_val = {kb_ready, 15'h0000};
        KBDR_ADDR: rd_val = {8'h00, kbdr};
        DSR_ADDR:  rd_val = {~dd_valid, 15'h0000};
        default:   rd_val = 16'h0000;
      endcase
    end
  end

  // Request sequencer: capture, count down the latency, pulse r for one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      r         <= 1'b0;
      mem_rdata <= 16'h0000;
      cap_addr  <= 16'h0000;
      cap_data  <= 16'h0000;
      cap_rw    <= 1'b0;
    end else begin
      r <= 1'b0;
      if (fire && !acc_rw) begin
        mem_rdata <= rd_val;
      end
      case (state)
        ST_IDLE: begin
          if (mio_en) begin
            cap_addr <= mar;
            cap_data <= mdr;
            cap_rw   <= r_w;
            cnt      <= WAIT_INIT;
            if (NO_WAIT) begin
              state <= ST_RESP;
              r     <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state <= ST_RESP;
            r     <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM write port; no reset so memory contents persist.
  always_ff @(posedge clk) begin
    if (fire && acc_rw && is_ram) begin
      ram[ram_idx] <= acc_data;
    end
  end

  // Keyboard registers: a new strobe always wins over a KBDR read clearing ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kb_ready <= 1'b0;
      kbdr     <= 8'h00;
    end else if (kb_valid) begin
      kb_ready <= 1'b1;
      kbdr     <= kb_data;
    end else if (fire && !acc_rw && (acc_addr == KBDR_ADDR)) begin
      kb_ready <= 1'b0;
    end
  end

  // Display register: a DDR write always leaves a character pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dd_valid <= 1'b0;
      dd_data  <= 8'h00;
    end else if (fire && acc_rw && (acc_addr == DDR_ADDR)) begin
      dd_valid <= 1'b1;
      dd_data  <= acc_data[7:0];
    end else if (dd_valid && dd_ready) begin
      dd_valid <= 1'b0;
    end
  end

endmodule
